pc_unit_gen2: RTL and testbench

- Second-generation RV32I program counter, parametrised in width, reset/trap vectors and RVC support.
- Adds 16-bit (compressed) sequential increments and a link-address output for rd writeback.
- Raises a misaligned-target fault and redirects to a trap vector.
- Contains a circular return-address stack (RAS) that records call link addresses and exposes the predicted return target to fetch.

---
 rtl/pc_unit_gen2.sv | 122 ++++++++++++
 tb/tb_pc_unit_gen2.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pc_unit_gen2.sv
// RV32I program counter with optional RVC increments, misaligned-target trap
// and a circular return-address stack that predicts return targets for fetch.
module pc_unit_gen2 #(
  parameter int              dataW    = 32,
  parameter logic [dataW-1:0] ResetVec = 16,
  parameter logic [dataW-1:0] TrapVec  = 8,
  parameter int              RasDepth = 4,
  parameter bit              CExt     = 1'b1
) (
  input  logic             clock,
  input  logic             nReset,
  input  logic             EQ,
  input  logic             NE,
  input  logic             LT,
  input  logic             LTU,
  input  logic             GE,
  input  logic             GEU,
  input  logic             TestBranch,
  input  logic             AlwaysBranch,
  input  logic             AbsoluteBranch,
  input  logic [2:0]       BranchType,
  input  logic [dataW-1:0] BranchAddr,
  input  logic             IsCompressed,
  input  logic             InsCacheStall,
  input  logic             PushRet,
  input  logic             PopRet,
  output logic [dataW-1:0] ProgAddr,
  output logic [dataW-1:0] LinkAddr,
  output logic [dataW-1:0] RasTop,
  output logic             RasEmpty,
  output logic             MisalignFault
);

  localparam int PtrW = $clog2(RasDepth);
  localparam int CntW = $clog2(RasDepth + 1);
  localparam logic [CntW-1:0] CountMax = CntW'(RasDepth);

  logic [dataW-1:0] inc;
  logic [dataW-1:0] tgt_raw;
  logic [dataW-1:0] tgt;
  logic [7:0]       flags;
  logic             taken;
  logic             misaligned;
  logic             ras_en;

  logic [dataW-1:0] ras [RasDepth];
  logic [PtrW-1:0]  ptr, ptr_nxt, wr_idx;
  logic [CntW-1:0]  count, count_nxt;
  logic             ras_wr;

  // Flag vector padded so BranchType 6 and 7 select a constant zero.
  assign flags      = {2'b00, GEU, GE, LTU, LT, NE, EQ};
  assign inc        = (CExt && IsCompressed) ? dataW'(2) : dataW'(4);
  assign LinkAddr   = ProgAddr + inc;
  assign tgt_raw    = AbsoluteBranch ? BranchAddr : ProgAddr + BranchAddr;
  assign tgt        = {tgt_raw[dataW-1:1], 1'b0};
  assign taken      = AlwaysBranch | (TestBranch & flags[BranchType]);
  assign misaligned = taken & !CExt & tgt[1];
  assign ras_en     = AlwaysBranch & !InsCacheStall & !misaligned;

  assign RasEmpty = (count == '0);
  assign RasTop   = RasEmpty ? '0 : ras[ptr];

  // NOTE: every output of a combinational block gets a default first, so no
  // path through the if-chain can leave a value held and infer a latch.
  always_comb begin
    ras_wr    = 1'b0;
    wr_idx    = ptr;
    ptr_nxt   = ptr;
    count_nxt = count;
    if (ras_en) begin
      if (PushRet && (!PopRet || RasEmpty)) begin
        ras_wr    = 1'b1;
        wr_idx    = ptr + 1'b1;
        ptr_nxt   = ptr + 1'b1;
        count_nxt = (count == CountMax) ? count : count + 1'b1;
      end else if (PushRet && PopRet) begin
        // Coroutine swap: replace the top in place.
        ras_wr = 1'b1;
      end else if (PopRet && !RasEmpty) begin
        ptr_nxt   = ptr - 1'b1;
        count_nxt = count - 1'b1;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ProgAddr      <= ResetVec;
      MisalignFault <= 1'b0;
    end else begin
      MisalignFault <= 1'b0;
      if (!InsCacheStall) begin
        if (misaligned) begin
          ProgAddr      <= TrapVec;
          MisalignFault <= 1'b1;
        end else if (taken) begin
          ProgAddr <= tgt;
        end else begin
          ProgAddr <= LinkAddr;
        end
      end
    end
  end

  // NOTE: the stack is small and RasTop is architecturally visible, so its
  // entries are reset explicitly instead of being left as uninitialised RAM.
  always_ff @(posedge clock or negedge nReset) begin
    if (!nReset) begin
      ptr   <= '0;
      count <= '0;
      for (int i = 0; i < RasDepth; i++) ras[i] <= '0;
    end else begin
      ptr   <= ptr_nxt;
      count <= count_nxt;
      if (ras_wr) ras[wr_idx] <= LinkAddr;
    end
  end

endmodule

// File: tb/tb_pc_unit_gen2.sv
// Directed bench for pc_unit_gen2: a vector table on an RVC-enabled instance
// plus hand sequences for the misaligned trap (RVC off), stall and async reset.
module tb_pc_unit_gen2;

  typedef struct {
    logic        tb_br;
    logic        al_br;
    logic        abs_br;
    logic [2:0]  btype;
    logic [31:0] addr;
    logic        comp;
    logic        push;
    logic        pop;
    logic [5:0]  flg;     // {GEU,GE,LTU,LT,NE,EQ}
    logic [31:0] link;    // expected LinkAddr before the edge
    logic [31:0] pc;      // expected ProgAddr after the edge
    logic        empty;
    logic [31:0] top;
  } vec_t;

  logic        clock = 1'b0;
  logic        nReset;
  logic        EQ, NE, LT, LTU, GE, GEU;
  logic        TestBranch, AlwaysBranch, AbsoluteBranch;
  logic [2:0]  BranchType;
  logic [31:0] BranchAddr;
  logic        IsCompressed, InsCacheStall, PushRet, PopRet;

  logic [31:0] pc1, link1, top1, pc0, link0, top0;
  logic        empty1, fault1, empty0, fault0;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  pc_unit_gen2 #(.CExt(1'b1)) dut_c (
    .clock(clock), .nReset(nReset),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
    .AbsoluteBranch(AbsoluteBranch), .BranchType(BranchType),
    .BranchAddr(BranchAddr), .IsCompressed(IsCompressed),
    .InsCacheStall(InsCacheStall), .PushRet(PushRet), .PopRet(PopRet),
    .ProgAddr(pc1), .LinkAddr(link1), .RasTop(top1),
    .RasEmpty(empty1), .MisalignFault(fault1)
  );

  pc_unit_gen2 #(.CExt(1'b0)) dut_n (
    .clock(clock), .nReset(nReset),
    .EQ(EQ), .NE(NE), .LT(LT), .LTU(LTU), .GE(GE), .GEU(GEU),
    .TestBranch(TestBranch), .AlwaysBranch(AlwaysBranch),
    .AbsoluteBranch(AbsoluteBranch), .BranchType(BranchType),
    .BranchAddr(BranchAddr), .IsCompressed(IsCompressed),
    .InsCacheStall(InsCacheStall), .PushRet(PushRet), .PopRet(PopRet),
    .ProgAddr(pc0), .LinkAddr(link0), .RasTop(top0),
    .RasEmpty(empty0), .MisalignFault(fault0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    {EQ, NE, LT, LTU, GE, GEU} = 6'b0;
    TestBranch = 1'b0; AlwaysBranch = 1'b0; AbsoluteBranch = 1'b0;
    BranchType = 3'd0; BranchAddr = 32'h0; IsCompressed = 1'b0;
    InsCacheStall = 1'b0; PushRet = 1'b0; PopRet = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clock);
    nReset = 1'b0;
    clear_inputs();
    @(negedge clock);
    nReset = 1'b1;
  endtask

  function automatic vec_t v(input logic tb_br, al_br, abs_br, input logic [2:0] btype,
                             input logic [31:0] addr, input logic comp, push, pop,
                             input logic [5:0] flg, input logic [31:0] link, pc,
                             input logic empty, input logic [31:0] top);
    vec_t r;
    r.tb_br = tb_br; r.al_br = al_br; r.abs_br = abs_br; r.btype = btype;
    r.addr = addr; r.comp = comp; r.push = push; r.pop = pop; r.flg = flg;
    r.link = link; r.pc = pc; r.empty = empty; r.top = top;
    return r;
  endfunction

  vec_t vecs[28];

  initial begin
    //             tb al ab bt    addr          c  pu po flags   link          pc            em top
    vecs[0]  = v(0, 0, 0, 3'd0, 32'h0,        0, 0, 0, 6'h00, 32'h14,       32'h14,       1, 32'h0);
    vecs[1]  = v(0, 0, 0, 3'd0, 32'h0,        0, 0, 0, 6'h00, 32'h18,       32'h18,       1, 32'h0);
    vecs[2]  = v(0, 0, 0, 3'd0, 32'h0,        0, 0, 0, 6'h00, 32'h1C,       32'h1C,       1, 32'h0);
    vecs[3]  = v(0, 1, 1, 3'd0, 32'h10,       0, 0, 0, 6'h00, 32'h20,       32'h10,       1, 32'h0);
    vecs[4]  = v(0, 0, 0, 3'd0, 32'h0,        1, 0, 0, 6'h00, 32'h12,       32'h12,       1, 32'h0);
    vecs[5]  = v(1, 0, 0, 3'd1, 32'hFFFFFFFE, 0, 0, 0, 6'h02, 32'h16,       32'h10,       1, 32'h0);
    vecs[6]  = v(1, 0, 0, 3'd1, 32'hFFFFFFFE, 0, 0, 0, 6'h00, 32'h14,       32'h14,       1, 32'h0);
    vecs[7]  = v(1, 0, 0, 3'd6, 32'h100,      0, 0, 0, 6'h3F, 32'h18,       32'h18,       1, 32'h0);
    vecs[8]  = v(1, 0, 0, 3'd2, 32'h8,        0, 0, 0, 6'h04, 32'h1C,       32'h20,       1, 32'h0);
    vecs[9]  = v(1, 0, 0, 3'd5, 32'h40,       0, 0, 0, 6'h1F, 32'h24,       32'h24,       1, 32'h0);
    vecs[10] = v(0, 1, 1, 3'd0, 32'h103,      0, 0, 0, 6'h00, 32'h28,       32'h102,      1, 32'h0);
    vecs[11] = v(0, 1, 1, 3'd0, 32'hFFFFFFFC, 0, 0, 0, 6'h00, 32'h106,      32'hFFFFFFFC, 1, 32'h0);
    vecs[12] = v(0, 0, 0, 3'd0, 32'h0,        0, 0, 0, 6'h00, 32'h0,        32'h0,        1, 32'h0);
    vecs[13] = v(0, 1, 0, 3'd0, 32'h20,       1, 0, 0, 6'h00, 32'h2,        32'h20,       1, 32'h0);
    vecs[14] = v(0, 1, 0, 3'd0, 32'hFFFFFFF1, 0, 0, 0, 6'h00, 32'h24,       32'h10,       1, 32'h0);
    vecs[15] = v(0, 1, 1, 3'd0, 32'h20,       0, 0, 0, 6'h00, 32'h14,       32'h20,       1, 32'h0);
    vecs[16] = v(0, 1, 1, 3'd0, 32'h40,       0, 1, 0, 6'h00, 32'h24,       32'h40,       0, 32'h24);
    vecs[17] = v(0, 1, 1, 3'd0, 32'h60,       0, 1, 0, 6'h00, 32'h44,       32'h60,       0, 32'h44);
    vecs[18] = v(0, 1, 1, 3'd0, 32'h80,       0, 1, 0, 6'h00, 32'h64,       32'h80,       0, 32'h64);
    vecs[19] = v(0, 1, 1, 3'd0, 32'hA0,       0, 1, 0, 6'h00, 32'h84,       32'hA0,       0, 32'h84);
    vecs[20] = v(0, 1, 1, 3'd0, 32'h100,      0, 1, 0, 6'h00, 32'hA4,       32'h100,      0, 32'hA4);
    vecs[21] = v(0, 1, 1, 3'd0, 32'h200,      0, 0, 1, 6'h00, 32'h104,      32'h200,      0, 32'h84);
    vecs[22] = v(0, 1, 1, 3'd0, 32'h300,      0, 0, 1, 6'h00, 32'h204,      32'h300,      0, 32'h64);
    vecs[23] = v(0, 1, 1, 3'd0, 32'h100,      0, 0, 1, 6'h00, 32'h304,      32'h100,      0, 32'h44);
    vecs[24] = v(0, 1, 1, 3'd0, 32'h400,      0, 1, 1, 6'h00, 32'h104,      32'h400,      0, 32'h104);
    vecs[25] = v(0, 1, 1, 3'd0, 32'h500,      0, 0, 1, 6'h00, 32'h404,      32'h500,      1, 32'h0);
    vecs[26] = v(0, 1, 1, 3'd0, 32'h600,      0, 0, 1, 6'h00, 32'h504,      32'h600,      1, 32'h0);
    vecs[27] = v(0, 0, 0, 3'd0, 32'h0,        0, 1, 0, 6'h00, 32'h604,      32'h604,      1, 32'h0);

    nReset = 1'b0;
    clear_inputs();
    #12;
    check("reset_pc", pc1, 32'h10);
    check("reset_empty", {31'b0, empty1}, 32'h1);
    check("reset_top", top1, 32'h0);
    check("reset_fault", {31'b0, fault1}, 32'h0);
    @(negedge clock);
    nReset = 1'b1;

    for (int i = 0; i < 28; i++) begin
      TestBranch = vecs[i].tb_br; AlwaysBranch = vecs[i].al_br;
      AbsoluteBranch = vecs[i].abs_br; BranchType = vecs[i].btype;
      BranchAddr = vecs[i].addr; IsCompressed = vecs[i].comp;
      PushRet = vecs[i].push; PopRet = vecs[i].pop;
      {GEU, GE, LTU, LT, NE, EQ} = vecs[i].flg;
      #1;
      check($sformatf("v%0d_link", i), link1, vecs[i].link);
      @(posedge clock); #1;
      check($sformatf("v%0d_pc", i), pc1, vecs[i].pc);
      check($sformatf("v%0d_empty", i), {31'b0, empty1}, {31'b0, vecs[i].empty});
      check($sformatf("v%0d_top", i), top1, vecs[i].top);
      check($sformatf("v%0d_fault", i), {31'b0, fault1}, 32'h0);
      @(negedge clock);
    end

    // Misaligned JALR without RVC: trap, one-cycle fault, push suppressed.
    do_reset();
    AlwaysBranch = 1'b1; AbsoluteBranch = 1'b1; BranchAddr = 32'h102; PushRet = 1'b1;
    @(posedge clock); #1;
    check("mis_pc", pc0, 32'h8);
    check("mis_fault", {31'b0, fault0}, 32'h1);
    check("mis_ras_empty", {31'b0, empty0}, 32'h1);
    @(negedge clock);
    clear_inputs();
    IsCompressed = 1'b1;
    #1;
    check("mis_link_nocext", link0, 32'hC);
    @(posedge clock); #1;
    check("mis_pc_next", pc0, 32'hC);
    check("mis_fault_drop", {31'b0, fault0}, 32'h0);
    @(negedge clock);
    clear_inputs();
    AlwaysBranch = 1'b1; AbsoluteBranch = 1'b1; BranchAddr = 32'h104; PushRet = 1'b1;
    @(posedge clock); #1;
    check("nocext_jump_pc", pc0, 32'h104);
    check("nocext_push_top", top0, 32'h10);
    check("nocext_fault", {31'b0, fault0}, 32'h0);

    // Stall freezes a taken call; releasing it applies the call on the next edge.
    do_reset();
    InsCacheStall = 1'b1; AlwaysBranch = 1'b1; AbsoluteBranch = 1'b1;
    BranchAddr = 32'h80; PushRet = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clock); #1;
      check($sformatf("stall%0d_pc", c), pc1, 32'h10);
      check($sformatf("stall%0d_empty", c), {31'b0, empty1}, 32'h1);
    end
    @(negedge clock);
    InsCacheStall = 1'b0;
    @(posedge clock); #1;
    check("unstall_pc", pc1, 32'h80);
    check("unstall_top", top1, 32'h14);
    @(negedge clock);
    clear_inputs();
    InsCacheStall = 1'b1;
    @(posedge clock); #1;
    check("stall_hold_pc", pc1, 32'h80);
    #2;
    nReset = 1'b0;
    #1;
    check("async_rst_pc", pc1, 32'h10);
    check("async_rst_empty", {31'b0, empty1}, 32'h1);
    check("async_rst_top", top1, 32'h0);
    @(negedge clock);
    nReset = 1'b1;
    InsCacheStall = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
